// File: rtl/countdown_display_pkg.sv
// Shared types and constants for the countdown display: converter states,
// panel colour codes, 7-segment patterns and digit slot indices.
package countdown_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  typedef enum logic [1:0] {
    COLOUR_NONE   = 2'b00,
    COLOUR_RED    = 2'b01,
    COLOUR_YELLOW = 2'b10,
    COLOUR_GREEN  = 2'b11
  } colour_t;

  // Segment patterns {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [1:0] DIG_ONES     = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  // Non-decimal nibbles decode to a dark digit
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/countdown_display_bin2bcd.sv
// Sequential double-dabble converter: 8-bit binary to three BCD nibbles,
// restarting whenever the input differs from the last value converted.
module bin2bcd_seq
  import countdown_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] count,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       done
);

  conv_state_t state_reg, state_next;
  logic [19:0] shift_reg;
  logic [19:0] adjusted;
  logic [7:0]  shadow_reg;
  logic        pending_reg;
  logic [3:0]  iter_reg;
  logic        start;

  assign start = (count != shadow_reg) || pending_reg;

  // Add-3 correction on each BCD nibble before the shift
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_reg[8 + 4*gi +: 4];
      assign adjusted[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate
  assign adjusted[7:0] = shift_reg[7:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (iter_reg == 4'd7) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b1;
      iter_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            shadow_reg  <= count;
            shift_reg   <= {12'd0, count};
            pending_reg <= 1'b0;
            iter_reg    <= '0;
          end
        end
        ST_SHIFT: begin
          shift_reg <= {adjusted[18:0], 1'b0};
          iter_reg  <= iter_reg + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd_hund = shift_reg[19:16];
  assign bcd_tens = shift_reg[15:12];
  assign bcd_ones = shift_reg[11:8];
  assign done     = (state_reg == ST_LOAD);

endmodule

// File: rtl/countdown_display.sv
// Multiplexed 3-digit countdown display with leading-zero blanking, low-value
// blinking and a registered lamp colour code.
module countdown_display
  import countdown_display_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_THRESH = 3,
  parameter int BLINK_DIV    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] count,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic [6:0] seg,
  output logic [2:0] dig_en,
  output logic [1:0] colour
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
  logic       conv_done;

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .count    (count),
    .bcd_hund (bcd_hund),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .done     (conv_done)
  );

  logic [3:0]         hund_reg, tens_reg, ones_reg;
  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [1:0]         scan_idx_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_phase_reg;
  logic [6:0]         seg_reg, seg_next;
  logic [2:0]         dig_en_reg, dig_en_next;
  colour_t            colour_reg, colour_next;

  logic       any_lamp;
  logic [3:0] digit_sel;
  logic       blank;
  logic [9:0] disp_value;
  logic       blink_off;

  assign any_lamp = red | yellow | green;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hund_reg        <= '0;
      tens_reg        <= '0;
      ones_reg        <= '0;
      scan_cnt_reg    <= '0;
      scan_idx_reg    <= DIG_ONES;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      if (conv_done) begin
        hund_reg <= bcd_hund;
        tens_reg <= bcd_tens;
        ones_reg <= bcd_ones;
      end
      if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt_reg <= '0;
        scan_idx_reg <= (scan_idx_reg == DIG_HUNDREDS) ? DIG_ONES : scan_idx_reg + 2'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
      end
      // Free-running: blink phase is never realigned to value changes
      if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
      end
    end
  end

  assign disp_value = 10'(hund_reg) * 10'd100 + 10'(tens_reg) * 10'd10 + 10'(ones_reg);
  assign blink_off  = (disp_value <= 10'(BLINK_THRESH)) && blink_phase_reg;

  always_comb begin
    digit_sel = ones_reg;
    blank     = 1'b0;
    case (scan_idx_reg)
      DIG_TENS: begin
        digit_sel = tens_reg;
        blank     = (hund_reg == 4'd0) && (tens_reg == 4'd0);
      end
      DIG_HUNDREDS: begin
        digit_sel = hund_reg;
        blank     = (hund_reg == 4'd0);
      end
      default: ;
    endcase
    seg_next = (!any_lamp || blank || blink_off) ? 7'h00 : seg_code(digit_sel);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dig
      assign dig_en_next[gi] = any_lamp && (scan_idx_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    colour_next = COLOUR_NONE;
    if (red)         colour_next = COLOUR_RED;
    else if (yellow) colour_next = COLOUR_YELLOW;
    else if (green)  colour_next = COLOUR_GREEN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg    <= '0;
      dig_en_reg <= '0;
      colour_reg <= COLOUR_NONE;
    end else begin
      seg_reg    <= seg_next;
      dig_en_reg <= dig_en_next;
      colour_reg <= colour_next;
    end
  end

  assign seg    = seg_reg;
  assign dig_en = dig_en_reg;
  assign colour = colour_reg;

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display: exact-latency sequences around reset,
// steady-state vector table, mid-conversion change, blink and async reset.
module tb_countdown_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] count = 8'd0;
  logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
  logic [6:0] seg;
  logic [2:0] dig_en;
  logic [1:0] colour;

  int checks = 0;
  int errors = 0;

  countdown_display #(.SCAN_DIV(4), .BLINK_THRESH(3), .BLINK_DIV(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .count  (count),
    .red    (red),
    .yellow (yellow),
    .green  (green),
    .seg    (seg),
    .dig_en (dig_en),
    .colour (colour)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [2:0] dig;
    logic [6:0] sg;
    logic [1:0] col;
  } timed_t;

  typedef struct {
    logic       r, y, g;
    logic [7:0] cnt;
    logic [6:0] s_ones, s_tens, s_hund;
    logic [1:0] col;
  } vec_t;

  localparam int N_TIMED = 12;
  localparam int N_VEC   = 12;
  timed_t timed [N_TIMED];
  vec_t   vecs  [N_VEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, actual, expected);
    end
  endtask

  // Edges counted from the first posedge after reset release
  task automatic run_timed(input int last_edge, input bit do_step);
    int ti;
    ti = 0;
    for (int k = 0; k <= last_edge; k++) begin
      step();
      if (ti < N_TIMED && timed[ti].edge_n == k) begin
        chk($sformatf("E%0d dig_en", k), int'(dig_en), int'(timed[ti].dig));
        chk($sformatf("E%0d seg", k), int'(seg), int'(timed[ti].sg));
        chk($sformatf("E%0d colour", k), int'(colour), int'(timed[ti].col));
        ti++;
      end
      if (do_step && k == 19) begin
        count = 8'd60;
        red   = 1'b0;
        green = 1'b1;
      end
    end
  endtask

  task automatic check_window(input string nm, input int ncyc, input bit lamp,
                              input logic [6:0] so, input logic [6:0] st,
                              input logic [6:0] sh, input logic [1:0] col);
    int n_o, n_t, n_h;
    n_o = 0; n_t = 0; n_h = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      chk($sformatf("%s c%0d colour", nm, c), int'(colour), int'(col));
      if (!lamp) begin
        chk($sformatf("%s c%0d dig_en", nm, c), int'(dig_en), 0);
        chk($sformatf("%s c%0d seg", nm, c), int'(seg), 0);
      end else begin
        case (dig_en)
          3'b001: begin n_o++; chk($sformatf("%s c%0d ones seg", nm, c), int'(seg), int'(so)); end
          3'b010: begin n_t++; chk($sformatf("%s c%0d tens seg", nm, c), int'(seg), int'(st)); end
          3'b100: begin n_h++; chk($sformatf("%s c%0d hund seg", nm, c), int'(seg), int'(sh)); end
          default: chk($sformatf("%s c%0d dig_en onehot", nm, c), int'(dig_en), 1);
        endcase
      end
    end
    if (lamp && (ncyc % 12 == 0)) begin
      chk($sformatf("%s ones slots", nm), n_o, ncyc / 3);
      chk($sformatf("%s tens slots", nm), n_t, ncyc / 3);
      chk($sformatf("%s hund slots", nm), n_h, ncyc / 3);
    end
  endtask

  initial begin
    int lit, dark, n_o;

    timed[0]  = '{0,  3'b001, 7'h3F, 2'b01};
    timed[1]  = '{3,  3'b001, 7'h3F, 2'b01};
    timed[2]  = '{4,  3'b010, 7'h00, 2'b01};
    timed[3]  = '{8,  3'b100, 7'h00, 2'b01};
    timed[4]  = '{12, 3'b001, 7'h3F, 2'b01};
    timed[5]  = '{16, 3'b010, 7'h06, 2'b01};
    timed[6]  = '{20, 3'b100, 7'h00, 2'b11};
    timed[7]  = '{24, 3'b001, 7'h3F, 2'b11};
    timed[8]  = '{29, 3'b010, 7'h06, 2'b11};
    timed[9]  = '{30, 3'b010, 7'h7D, 2'b11};
    timed[10] = '{36, 3'b001, 7'h3F, 2'b11};
    timed[11] = '{40, 3'b010, 7'h7D, 2'b11};

    //            r  y  g  count  ones   tens   hund   colour
    vecs[0]  = '{1, 0, 0, 8'd10,  7'h3F, 7'h06, 7'h00, 2'b01};
    vecs[1]  = '{0, 0, 1, 8'd60,  7'h3F, 7'h7D, 7'h00, 2'b11};
    vecs[2]  = '{0, 1, 0, 8'd255, 7'h6D, 7'h6D, 7'h5B, 2'b10};
    vecs[3]  = '{1, 0, 0, 8'd7,   7'h07, 7'h00, 7'h00, 2'b01};
    vecs[4]  = '{0, 1, 0, 8'd4,   7'h66, 7'h00, 7'h00, 2'b10};
    vecs[5]  = '{0, 0, 0, 8'd10,  7'h00, 7'h00, 7'h00, 2'b00};
    vecs[6]  = '{1, 0, 1, 8'd10,  7'h3F, 7'h06, 7'h00, 2'b01};
    vecs[7]  = '{0, 1, 1, 8'd205, 7'h6D, 7'h3F, 7'h5B, 2'b10};
    vecs[8]  = '{1, 0, 0, 8'd100, 7'h3F, 7'h3F, 7'h06, 2'b01};
    vecs[9]  = '{0, 0, 1, 8'd9,   7'h6F, 7'h00, 7'h00, 2'b11};
    vecs[10] = '{1, 1, 1, 8'd123, 7'h4F, 7'h5B, 7'h06, 2'b01};
    vecs[11] = '{0, 0, 1, 8'd88,  7'h7F, 7'h7F, 7'h00, 2'b11};

    // Reset with red lit and count=10 already presented
    red   = 1'b1;
    count = 8'd10;
    #2 rst_n = 1'b0;
    #12;
    chk("reset seg", int'(seg), 0);
    chk("reset dig_en", int'(dig_en), 0);
    chk("reset colour", int'(colour), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_timed(43, 1'b1);

    // Steady-state vector table
    for (int v = 0; v < N_VEC; v++) begin
      red = vecs[v].r; yellow = vecs[v].y; green = vecs[v].g; count = vecs[v].cnt;
      repeat (24) step();
      check_window($sformatf("vec%0d", v), 12, vecs[v].r | vecs[v].y | vecs[v].g,
                   vecs[v].s_ones, vecs[v].s_tens, vecs[v].s_hund, vecs[v].col);
    end

    // 255 then 7 during the third SHIFT cycle: 255 must still be shown, then 7
    red = 1'b1; yellow = 1'b0; green = 1'b0; count = 8'd255;
    for (int g = 0; g < 10; g++) begin
      step();
      if (g == 2) count = 8'd7;
    end
    check_window("show255", 10, 1'b1, 7'h6D, 7'h6D, 7'h5B, 2'b01);
    repeat (2) step();
    check_window("show7", 12, 1'b1, 7'h07, 7'h00, 7'h00, 2'b01);

    // Blink at count=3: ones slot lit for half of its cycles over one 48-cycle period
    red = 1'b0; yellow = 1'b1; count = 8'd3;
    repeat (24) step();
    lit = 0; dark = 0; n_o = 0;
    for (int c = 0; c < 48; c++) begin
      step();
      chk($sformatf("blink c%0d colour", c), int'(colour), 2);
      if (dig_en == 3'b001) begin
        n_o++;
        if (seg == 7'h4F) lit++;
        else if (seg == 7'h00) dark++;
        else chk($sformatf("blink c%0d ones seg", c), int'(seg), 'h4F);
      end else begin
        chk($sformatf("blink c%0d blank seg", c), int'(seg), 0);
        chk($sformatf("blink c%0d dig_en scan", c),
            int'((dig_en == 3'b010) || (dig_en == 3'b100)), 1);
      end
    end
    chk("blink ones slots", n_o, 16);
    chk("blink lit cycles", lit, 8);
    chk("blink dark cycles", dark, 8);
    count = 8'd4;
    repeat (24) step();
    check_window("noblink4", 48, 1'b1, 7'h66, 7'h00, 7'h00, 2'b10);

    // Async reset mid-SHIFT and mid-scan, then reconversion of 10
    yellow = 1'b0; red = 1'b1; count = 8'd10;
    repeat (3) step();
    chk("pre-reset dig_en lit", int'(dig_en != 3'b000), 1);
    chk("pre-reset colour", int'(colour), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset seg", int'(seg), 0);
    chk("async reset dig_en", int'(dig_en), 0);
    chk("async reset colour", int'(colour), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_timed(19, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
Name: countdown_display

Overview:
- Downstream consumer of the traffic-light controller. Takes its 8-bit countdown value and its red/yellow/green lamp outputs.
- Converts the countdown to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a 3-digit multiplexed 7-segment display, plus a 2-bit lamp colour code for the panel.
- Blanks the display while no lamp is lit. Blinks the digits during the final seconds of a phase.

Parameters:
- SCAN_DIV, 4: clk cycles each digit stays selected before the scan advances; legal range ≥1.
- BLINK_THRESH, 3: displayed value at or below which the digits blink (value 0 also blinks).
- BLINK_DIV, 8: clk cycles per blink half-period (on phase, then off phase); legal range ≥1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; asynchronous, active-low.
- count  input  8  countdown value from the traffic-light controller, binary 0..255.
- red  input  1  red lamp from the controller.
- yellow  input  1  yellow lamp from the controller.
- green  input  1  green lamp from the controller.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.
- dig_en  output  3  one-hot digit select: bit0 ones, bit1 tens, bit2 hundreds; active-high.
- colour  output  2  00 none, 01 red, 10 yellow, 11 green.

Behaviour:
- Reset (async, rst_n=0):
  - seg=0, dig_en=0, colour=0.
  - Digit registers = 0; scan index = 0; scan and blink counters = 0; converter FSM = IDLE.
  - Shadow register = 0 with pending flag = 1, so the first post-reset edge starts a conversion.
- Converter FSM, states IDLE, SHIFT, LOAD:
  - IDLE→SHIFT at an edge where (count != shadow) or pending. At that edge: capture count into shadow and shift register, clear pending, clear the 4-bit iteration counter.
  - SHIFT: 8 cycles. Each cycle, first add 3 to every BCD nibble ≥5, then shift left by 1. Iteration counter 0..7; on 7 go to LOAD.
  - LOAD: copy the hundreds/tens/ones nibbles into the digit registers; →IDLE.
  - Latency: count sampled at edge E0; digit registers hold the new value after edge E9. A new conversion can start at E10 at the earliest.
  - count changes during SHIFT/LOAD are ignored. Comparison against shadow on return to IDLE guarantees the final settled value is always displayed.
  - Reset mid-conversion aborts it; the digit registers return to 0.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 every cycle. On wrap, index advances 0→1→2→0.
  - dig_en and seg are registered, one cycle behind index.
  - dig_en = one-hot(index) whenever any lamp is lit.
- Leading-zero blanking:
  - Hundreds is blank when its digit is 0.
  - Tens is blank when both hundreds and tens are 0.
  - Ones is never blanked.
  - A blanked digit drives seg=0 but keeps dig_en asserted.
- Segment codes 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. Nibbles >9 cannot occur; if decoded, drive seg=0.
- Blink:
  - Blink counter counts 0..BLINK_DIV-1 and toggles the phase bit on wrap. It free-runs and is not reset on value change.
  - When the displayed value (digit registers) ≤ BLINK_THRESH and the phase bit = 1: seg=0, while dig_en keeps scanning.
- No lamp lit (red=yellow=green=0, e.g. the controller's post-reset idle cycle): seg=0, dig_en=0, colour=00. The converter still runs.
- Colour:
  - Registered, one cycle latency.
  - Priority red > yellow > green if more than one lamp is lit simultaneously.

Decomposition:
- Shared package:
  - Converter state enum (IDLE, SHIFT, LOAD).
  - Colour codes (NONE, RED, YELLOW, GREEN).
  - The 10-entry 7-segment code constants.
  - Digit index constants.
- One sub-module: bin2bcd_seq.
  - Contents: converter FSM, shift register, iteration counter, shadow/pending logic.
  - Interface: clk, rst_n, count in; 3×4-bit BCD out, plus a 1-cycle done pulse asserted in LOAD.
- Top level: scan counter, blink counter, blanking, segment decode, output registers.

Test Plan:
- Reset, then red=1, count=10 held (SCAN_DIV=4): digit registers =0,1,0 after edge 9 → dig_en 001/010/100, each for 4 cycles. Ones seg=3F, tens seg=06, hundreds seg=00. colour=01.
- count steps 10→60 when green rises: tens seg=7D and ones seg=3F exactly from the first scan slot after E9. colour=11 one cycle after green.
- count=255, then changed to 7 at the 3rd cycle of SHIFT: display first shows 2,5,5 (5B,6D,6D), then converts again and shows 7 with hundreds and tens blanked (seg=0 in those slots).
- count=3 with yellow=1 (BLINK_DIV=8): seg in the ones slot alternates 4F for 8 cycles and 00 for 8 cycles, while dig_en keeps scanning. count=4 → no blinking.
- All lamps 0 with count=10: dig_en=000, seg=00, colour=00. red and green both 1 → colour=01.
- rst_n pulsed low asynchronously mid-SHIFT and mid-scan: outputs go to 0 immediately without waiting for clk. After release with red=1 and count unchanged, the value is reconverted and displayed 10 cycles later.
